demux16_capture: RTL and testbench

//  Serial-to-parallel capture: the receive-side counterpart of the 16:1 mux path.
//  - An internal 4-bit pointer acts as the demux select. It steers each accepted serial bit into out_word[ptr].
//  - After 16 bits, the assembled word is presented on a valid/ready output port.
//  - Placement: downstream of any 16:1 mux serializer, reassembling its stream.

---
 rtl/demux16_pkg.sv | 22 ++
 rtl/demux16_decode.sv | 21 ++
 rtl/demux16_capture.sv | 76 +++++++
 tb/tb_demux16_capture.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux16_pkg.sv
// Shared constants and state encoding for the 16-bit serial capture block.
// DEMUX16_MSB_FIRST_EN selects MSB-first pointer order (default LSB-first).
package demux16_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SEL_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

`ifdef DEMUX16_MSB_FIRST_EN
  localparam int PTR_FIRST = WIDTH_DEF - 1;
  localparam int PTR_LAST  = 0;
`else
  localparam int PTR_FIRST = 0;
  localparam int PTR_LAST  = WIDTH_DEF - 1;
`endif

endpackage

// File: rtl/demux16_decode.sv
// One-hot pointer decoder producing per-bit write enables
// for the capture register bank.
module demux16_decode
  import demux16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [WIDTH-1:0] we
);

  always_comb begin
    we = '0;
    for (int i = 0; i < WIDTH; i++) begin
      we[i] = en && (ptr == SEL_W'(i));
    end
  end

endmodule

// File: rtl/demux16_capture.sv
// Serial-to-parallel capture with valid/ready output and sticky overrun.
// Bit order set by DEMUX16_MSB_FIRST_EN (undefined: LSB-first).
module demux16_capture
  import demux16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  // Package gives the order for the default width; scale to WIDTH.
  localparam logic [SEL_W-1:0] P_FIRST =
    (PTR_FIRST == 0) ? '0 : SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] P_LAST =
    (PTR_LAST == 0) ? '0 : SEL_W'(WIDTH - 1);
  localparam bit DOWN = (PTR_FIRST > PTR_LAST);

  state_t           state;
  state_t           state_nx;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nx;
  logic [WIDTH-1:0] we;
  logic             accept;

  assign in_ready  = (state != ST_HOLD);
  assign out_valid = (state == ST_HOLD);
  assign busy      = (state == ST_FILL);
  assign accept    = in_valid & in_ready;
  assign ptr_nx    = DOWN ? ptr - SEL_W'(1) : ptr + SEL_W'(1);

  demux16_decode #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_decode (
    .ptr (ptr),
    .en  (accept),
    .we  (we)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept) state_nx = ST_FILL;
      ST_FILL: if (accept && ptr == P_LAST) state_nx = ST_HOLD;
      ST_HOLD: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= P_FIRST;
      out_word <= '0;
      overrun  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) ptr <= ptr_nx;
      for (int i = 0; i < WIDTH; i++) begin
        if (we[i]) out_word[i] <= in_bit;
      end
      if (in_valid && !in_ready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demux16_capture.sv
// Directed self-checking bench for demux16_capture.
// Bit order follows DEMUX16_MSB_FIRST_EN, matching the DUT build.
module tb_demux16_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_bit;
  logic        in_ready;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

`ifdef DEMUX16_MSB_FIRST_EN
  localparam logic [15:0] FIRST_ONE = 16'h8000;
`else
  localparam logic [15:0] FIRST_ONE = 16'h0001;
`endif

  always #5 clk = ~clk;

  demux16_capture dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  function automatic logic bit_of(input logic [15:0] w, input int k);
`ifdef DEMUX16_MSB_FIRST_EN
    return w[15-k];
`else
    return w[k];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_bit = 1'b0;
    out_ready = 1'b0;
    do_reset(2);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
        overrun !== 1'b0 || out_word !== 16'h0000) begin
      errors++;
      $display("FAIL reset_init: ov=%b busy=%b ir=%b orun=%b word=%h",
               out_valid, busy, in_ready, overrun, out_word);
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_bit = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prefill_busy: got %b want 1", busy);
    end
    do_reset(2);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
        overrun !== 1'b0 || out_word !== 16'h0000) begin
      errors++;
      $display("FAIL reset_midfill: ov=%b busy=%b ir=%b orun=%b word=%h",
               out_valid, busy, in_ready, overrun, out_word);
    end
    in_valid = 1'b1;
    in_bit = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_word !== FIRST_ONE) begin
      errors++;
      $display("FAIL reset_restart_idx: got %h want %h", out_word, FIRST_ONE);
    end
    do_reset(1);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_bit = bit_of(16'h3f0a, k);
      tick();
      if (k == 14) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_early_valid: got %b want 0", out_valid);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_word !== 16'h3f0a || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_word: ov=%b word=%h ir=%b want 1 3f0a 0",
               out_valid, out_word, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: ov=%b ir=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_bit = bit_of(16'hA5C3, k);
      tick();
    end
    in_valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_word !== 16'hA5C3)
        bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d bad cycles want 0 (word=%h)", bad, out_word);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_overrun: got %b want 0", overrun);
    end
    in_valid = 1'b1;
    in_bit = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1 || out_word !== 16'hA5C3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_overrun: orun=%b word=%h ov=%b want 1 a5c3 1",
               overrun, out_word, out_valid);
    end
    out_ready = 1'b1;
    tick();
    repeat (3) tick();
    checks++;
    if (overrun !== 1'b1 || out_valid !== 1'b0 || out_word !== 16'hA5C3) begin
      errors++;
      $display("FAIL bp_sticky: orun=%b ov=%b word=%h want 1 0 a5c3",
               overrun, out_valid, out_word);
    end
    do_reset(1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_clear: got %b want 0", overrun);
    end
  endtask

  task automatic test_gappy();
    int bad;
    out_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_bit = bit_of(16'h8001, k);
      tick();
      if (k < 15) begin
        in_valid = 1'b0;
        in_bit = 1'b1;
        repeat (2) begin
          if (busy !== 1'b1 || out_valid !== 1'b0) bad++;
          tick();
        end
        if (busy !== 1'b1) bad++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gap_busy: %0d bad samples want 0", bad);
    end
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || out_word !== 16'h8001) begin
      errors++;
      $display("FAIL gap_word: ov=%b busy=%b word=%h want 1 0 8001",
               out_valid, busy, out_word);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL gap_release: ov=%b orun=%b want 0 0", out_valid, overrun);
    end
  endtask

  task automatic test_back_to_back();
    int stalls;
    out_ready = 1'b1;
    stalls = 0;
    for (int c = 0; c < 33; c++) begin
      in_valid = 1'b1;
      if (c < 16) in_bit = 1'b1;
      else if (c == 16) in_bit = 1'b1;
      else in_bit = bit_of(16'h0000, c - 17);
      if (in_ready === 1'b0) stalls++;
      if (c == 16) begin
        checks++;
        if (out_valid !== 1'b1 || out_word !== 16'hFFFF) begin
          errors++;
          $display("FAIL b2b_first: ov=%b word=%h want 1 ffff",
                   out_valid, out_word);
        end
      end
      tick();
      if (c == 16) begin
        checks++;
        if (overrun !== 1'b1 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stall: orun=%b ir=%b want 1 1", overrun, in_ready);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (stalls != 1) begin
      errors++;
      $display("FAIL b2b_stall_count: got %0d want 1", stalls);
    end
    checks++;
    if (out_valid !== 1'b1 || out_word !== 16'h0000 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: ov=%b word=%h orun=%b want 1 0000 1",
               out_valid, out_word, overrun);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_bit = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gappy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
